// File: rtl/detector_veiculo.sv
// Vehicle request conditioner for the traffic-light controller: synchronises and debounces
// the loop sensor, turns each new arrival into a CAR request gated by a minimum green time.
module detector_veiculo #(
   parameter int unsigned DEBOUNCE   = 500000,
   parameter int unsigned TMIN_VERDE = 250000000,
   parameter int unsigned CNT_W      = 32
) (
   input  logic       clk,
   input  logic       res,
   input  logic       SENSOR,
   input  logic       VERDE,
   output logic       CAR,
   output logic       PRESENCA,
   output logic [7:0] PEDIDOS
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ESPERA  = 2'd1,
      PEDIDO  = 2'd2,
      SERVIDO = 2'd3
   } estado_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 32'd1);
   localparam logic [CNT_W-1:0] G_MAX    = CNT_W'(TMIN_VERDE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   logic             s1_r, s2_r;
   logic [CNT_W-1:0] deb_cnt_r;
   logic             presenca_r, pres_d_r;
   logic [CNT_W-1:0] g_cnt_r;
   estado_t          state_r, state_nxt_s;
   logic             pendente_r, pendente_nxt_s;
   logic [7:0]       pedidos_r, pedidos_nxt_s;
   logic             car_r;
   logic             chegada_s, verde_ok_s;

   assign chegada_s  = presenca_r & ~pres_d_r;
   assign verde_ok_s = VERDE & (g_cnt_r == G_MAX);

   // Two-flop synchroniser for the asynchronous sensor.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= SENSOR;
         s2_r <= s1_r;
      end
   end

   // Debounce: PRESENCA follows s2 only after DEBOUNCE consecutive mismatching cycles.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         deb_cnt_r  <= '0;
         presenca_r <= 1'b0;
         pres_d_r   <= 1'b0;
      end else begin
         pres_d_r <= presenca_r;
         if (s2_r == presenca_r) begin
            deb_cnt_r <= '0;
         end else if (deb_cnt_r == DEB_LAST) begin
            presenca_r <= s2_r;
            deb_cnt_r  <= '0;
         end else begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE;
         end
      end
   end

   // Consecutive-green counter, saturating at the minimum green time.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         g_cnt_r <= '0;
      end else if (!VERDE) begin
         g_cnt_r <= '0;
      end else if (g_cnt_r != G_MAX) begin
         g_cnt_r <= g_cnt_r + CNT_ONE;
      end else begin
         g_cnt_r <= g_cnt_r;
      end
   end

   // Request FSM next-state; arrivals while a request is open merge into it.
   always_comb begin
      state_nxt_s    = state_r;
      pendente_nxt_s = pendente_r;
      pedidos_nxt_s  = pedidos_r;
      case (state_r)
         IDLE: begin
            if (chegada_s || pendente_r) begin
               pendente_nxt_s = 1'b0;
               if (verde_ok_s) begin
                  state_nxt_s = PEDIDO;
               end else begin
                  state_nxt_s = ESPERA;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ESPERA: begin
            if (verde_ok_s) begin
               state_nxt_s = PEDIDO;
            end else begin
               state_nxt_s = ESPERA;
            end
         end
         PEDIDO: begin
            if (!VERDE) begin
               state_nxt_s = SERVIDO;
               if (pedidos_r != 8'd255) begin
                  pedidos_nxt_s = pedidos_r + 8'd1;
               end else begin
                  pedidos_nxt_s = pedidos_r;
               end
            end else begin
               state_nxt_s = PEDIDO;
            end
         end
         SERVIDO: begin
            if (chegada_s) begin
               pendente_nxt_s = 1'b1;
            end else begin
               pendente_nxt_s = pendente_r;
            end
            if (VERDE) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SERVIDO;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and output registers; CAR is registered alongside the state it decodes.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_r    <= IDLE;
         pendente_r <= 1'b0;
         pedidos_r  <= 8'd0;
         car_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         pendente_r <= pendente_nxt_s;
         pedidos_r  <= pedidos_nxt_s;
         car_r      <= (state_nxt_s == PEDIDO);
      end
   end

   assign CAR      = car_r;
   assign PRESENCA = presenca_r;
   assign PEDIDOS  = pedidos_r;

endmodule

// File: tb/tb_detector_veiculo.sv
// Bench for detector_veiculo: directed scenarios plus random sensor/green traffic,
// checked every cycle against a behavioural model of the request rules.
module tb_detector_veiculo;

   localparam int DEB  = 4;
   localparam int TMIN = 10;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       SENSOR = 1'b0;
   logic       VERDE = 1'b0;
   logic       CAR, PRESENCA;
   logic [7:0] PEDIDOS;

   int total = 0;
   int bad   = 0;

   detector_veiculo #(.DEBOUNCE(DEB), .TMIN_VERDE(TMIN), .CNT_W(32)) dut (
      .clk(clk), .res(res), .SENSOR(SENSOR), .VERDE(VERDE),
      .CAR(CAR), .PRESENCA(PRESENCA), .PEDIDOS(PEDIDOS)
   );

   always #5 clk = ~clk;

   // Behavioural model: sensor history, stable-run length, green run, request bookkeeping.
   bit sens_hist [0:1];
   bit m_pres, m_pres_prev;
   int m_run, m_green, m_served;
   bit m_car, m_want, m_back, m_pend;
   bit m_arrival, m_ok;

   assign m_arrival = m_pres && !m_pres_prev;
   assign m_ok      = VERDE && (m_green >= TMIN);

   always @(posedge clk or negedge res) begin
      if (!res) begin
         sens_hist[0] <= 1'b0; sens_hist[1] <= 1'b0;
         m_pres <= 1'b0; m_pres_prev <= 1'b0; m_run <= 0; m_green <= 0;
         m_served <= 0; m_car <= 1'b0; m_want <= 1'b0; m_back <= 1'b0; m_pend <= 1'b0;
      end else begin
         sens_hist[0] <= SENSOR;
         sens_hist[1] <= sens_hist[0];
         m_pres_prev  <= m_pres;
         if (sens_hist[1] != m_pres) begin
            if (m_run + 1 >= DEB) begin
               m_pres <= sens_hist[1];
               m_run  <= 0;
            end else begin
               m_run <= m_run + 1;
            end
         end else begin
            m_run <= 0;
         end
         m_green <= VERDE ? ((m_green < TMIN) ? m_green + 1 : TMIN) : 0;
         if (m_car) begin
            if (!VERDE) begin
               m_car    <= 1'b0;
               m_back   <= 1'b1;
               m_served <= (m_served < 255) ? m_served + 1 : 255;
            end
         end else if (m_back) begin
            if (m_arrival) m_pend <= 1'b1;
            if (VERDE) m_back <= 1'b0;
         end else if (m_want) begin
            if (m_ok) begin
               m_car  <= 1'b1;
               m_want <= 1'b0;
            end
         end else if (m_arrival || m_pend) begin
            m_pend <= 1'b0;
            if (m_ok) m_car <= 1'b1;
            else m_want <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // One clock cycle: sample #1 after the edge and compare against the model.
   task automatic step();
      @(posedge clk);
      #1;
      if (res) begin
         total++;
         if (CAR !== m_car || PRESENCA !== m_pres || PEDIDOS !== 8'(m_served)) begin
            bad++;
            $display("FAIL model t=%0t CAR=%b/%b PRESENCA=%b/%b PEDIDOS=%0d/%0d",
                     $time, CAR, m_car, PRESENCA, m_pres, PEDIDOS, m_served);
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int s_hold, v_hold;

      // Reset state
      steps(2);
      chk("rst_car", CAR, 0);
      chk("rst_pres", PRESENCA, 0);
      chk("rst_ped", PEDIDOS, 0);
      res = 1'b1;
      step();

      // Glitch rejection with green held
      VERDE = 1'b1;
      SENSOR = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         if (k == 4) SENSOR = 1'b0;
         step();
         chk("glitch_pres", PRESENCA, 0);
         chk("glitch_car", CAR, 0);
      end

      // Clean arrival with green already long enough
      SENSOR = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         chk("arr_pres", PRESENCA, (k >= 6) ? 1 : 0);
         chk("arr_car", CAR, (k >= 7) ? 1 : 0);
      end
      VERDE = 1'b0;
      step();
      chk("serve1_car", CAR, 0);
      chk("serve1_ped", PEDIDOS, 1);

      // Arrival while served and red: pending request after green returns
      SENSOR = 1'b0;
      steps(8);
      SENSOR = 1'b1;
      steps(10);
      chk("pend_car", CAR, 0);
      chk("pend_ped", PEDIDOS, 1);
      VERDE = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         step();
         chk("pend_wait_car", CAR, (k >= 11) ? 1 : 0);
      end
      VERDE = 1'b0;
      step();
      chk("serve2_car", CAR, 0);
      chk("serve2_ped", PEDIDOS, 2);

      // Minimum green: presence rises 3 edges into green, CAR on edge 11
      SENSOR = 1'b0;
      steps(8);
      VERDE = 1'b1; step();
      VERDE = 1'b0; steps(2);
      SENSOR = 1'b1; steps(3);
      VERDE = 1'b1;
      for (int j = 1; j <= 11; j++) begin
         step();
         chk("ming_car", CAR, (j >= 11) ? 1 : 0);
      end
      VERDE = 1'b0;
      step();
      chk("serve3_ped", PEDIDOS, 3);

      // Green interrupted during the wait restarts the timer
      SENSOR = 1'b0;
      steps(8);
      VERDE = 1'b1; step();
      VERDE = 1'b0; steps(2);
      SENSOR = 1'b1; steps(3);
      VERDE = 1'b1; steps(2);
      VERDE = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         step();
         chk("intr_car", CAR, 0);
      end
      VERDE = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         step();
         chk("intr_wait_car", CAR, (k >= 11) ? 1 : 0);
      end

      // Asynchronous reset mid-cycle while requesting
      #2 res = 1'b0;
      #1;
      chk("async_car", CAR, 0);
      chk("async_pres", PRESENCA, 0);
      chk("async_ped", PEDIDOS, 0);
      @(posedge clk);
      #2 res = 1'b1;
      step();
      chk("post_rst_car", CAR, 0);
      chk("post_rst_ped", PEDIDOS, 0);

      // Random traffic
      s_hold = 0;
      v_hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (s_hold == 0) begin
            SENSOR = 1'($urandom_range(1, 0));
            s_hold = $urandom_range(12, 1);
         end else begin
            s_hold--;
         end
         if (v_hold == 0) begin
            VERDE  = 1'($urandom_range(1, 0));
            v_hold = $urandom_range(30, 1);
         end else begin
            v_hold--;
         end
         step();
      end

      // Saturation of the served counter
      res = 1'b0;
      step();
      res = 1'b1;
      SENSOR = 1'b0;
      VERDE = 1'b0;
      steps(7);
      for (int n = 0; n < 260; n++) begin
         SENSOR = 1'b1; VERDE = 1'b1;
         steps(12);
         SENSOR = 1'b0; VERDE = 1'b0;
         steps(7);
      end
      chk("sat_ped", PEDIDOS, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
